// File: rtl/intt_stage_ctrl.sv
// Address sequencer for one Gentleman-Sande INTT layer: issues coefficient/twiddle
// reads for every butterfly pair of a stage and replays the addresses as write-backs.
module intt_stage_ctrl #(
  parameter int LOG_N            = 8,
  parameter int LOG_N_W          = 3,
  parameter int MULRED_PIP_LEVEL = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [LOG_N_W-1:0] i_stage,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_rd_en,
  output logic [LOG_N-1:0]   o_rd_addr_u,
  output logic [LOG_N-1:0]   o_rd_addr_v,
  output logic [LOG_N-1:0]   o_tw_addr,
  output logic               o_wr_en,
  output logic [LOG_N-1:0]   o_wr_addr_u,
  output logic [LOG_N-1:0]   o_wr_addr_v,
  output logic [1:0]         o_dbg_state
);

  localparam int BF_LAT = MULRED_PIP_LEVEL + 1;
  localparam int DL     = 1 + BF_LAT;
  localparam int DW     = $clog2(BF_LAT + 1);
  localparam logic [LOG_N-1:0] HALF_N  = LOG_N'(1) << (LOG_N - 1);
  localparam logic [31:0]      LOG_N_U = 32'(LOG_N);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t             state;
  logic [LOG_N_W-1:0] stage_q;
  logic [LOG_N-1:0]   k_q;
  logic [DW-1:0]      drain_q;

  logic               dl_valid [DL];
  logic [LOG_N-1:0]   dl_u     [DL];
  logic [LOG_N-1:0]   dl_v     [DL];

  logic [LOG_N_W-1:0] addr_s;
  logic [LOG_N-1:0]   addr_k, len, grp, idx, nxt_u, nxt_v, nxt_tw;
  logic               stage_ok;

  // Start handshake: i_start is a one-cycle request with no ready; it is accepted
  // only in IDLE with a legal stage, otherwise it is dropped (never queued).
  assign stage_ok    = 32'(i_stage) < LOG_N_U;
  assign o_dbg_state = state;

  // Pair k of stage s: group = k >> s, index inside group = k & (len-1).
  always_comb begin
    addr_s = (state == IDLE) ? i_stage : stage_q;
    addr_k = (state == IDLE) ? '0 : k_q;
    len    = LOG_N'(1) << addr_s;
    grp    = addr_k >> addr_s;
    idx    = addr_k & (len - LOG_N'(1));
    nxt_u  = ((grp << addr_s) << 1) | idx;
    nxt_v  = nxt_u + len;
    nxt_tw = (HALF_N >> addr_s) + grp;
  end

  // The delay-line head is the write port, so a read at t writes at t+DL.
  assign o_wr_en     = dl_valid[DL-1];
  assign o_wr_addr_u = dl_u[DL-1];
  assign o_wr_addr_v = dl_v[DL-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      stage_q     <= '0;
      k_q         <= '0;
      drain_q     <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_rd_en     <= 1'b0;
      o_rd_addr_u <= '0;
      o_rd_addr_v <= '0;
      o_tw_addr   <= '0;
      for (int i = 0; i < DL; i++) begin
        dl_valid[i] <= 1'b0;
        dl_u[i]     <= '0;
        dl_v[i]     <= '0;
      end
    end else begin
      o_done      <= 1'b0;
      dl_valid[0] <= o_rd_en;
      dl_u[0]     <= o_rd_addr_u;
      dl_v[0]     <= o_rd_addr_v;
      for (int i = 1; i < DL; i++) begin
        dl_valid[i] <= dl_valid[i-1];
        dl_u[i]     <= dl_u[i-1];
        dl_v[i]     <= dl_v[i-1];
      end
      case (state)
        IDLE: begin
          if (i_start && stage_ok) begin
            state       <= RUN;
            stage_q     <= i_stage;
            k_q         <= LOG_N'(1);
            o_busy      <= 1'b1;
            o_rd_en     <= 1'b1;
            o_rd_addr_u <= nxt_u;
            o_rd_addr_v <= nxt_v;
            o_tw_addr   <= nxt_tw;
          end
        end
        RUN: begin
          if (k_q == HALF_N) begin
            o_rd_en <= 1'b0;
            drain_q <= '0;
            state   <= DRAIN;
          end else begin
            o_rd_addr_u <= nxt_u;
            o_rd_addr_v <= nxt_v;
            o_tw_addr   <= nxt_tw;
            k_q         <= k_q + LOG_N'(1);
          end
        end
        DRAIN: begin
          // Leave once the last pair has reached the delay-line head.
          if (drain_q == DW'(BF_LAT)) begin
            state  <= IDLE;
            k_q    <= '0;
            o_busy <= 1'b0;
            o_done <= 1'b1;
          end else begin
            drain_q <= drain_q + DW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_intt_stage_ctrl.sv
// Bench for intt_stage_ctrl: cycle-level model of read/write schedules from the
// pair-address arithmetic, plus literal spot checks of known pairs.
module tb_intt_stage_ctrl;

  localparam int LOG_N            = 8;
  localparam int LOG_N_W          = 4;
  localparam int MULRED_PIP_LEVEL = 5;
  localparam int BF_LAT           = MULRED_PIP_LEVEL + 1;
  localparam int N                = 1 << LOG_N;
  localparam int HALF             = N / 2;
  localparam int QW               = 32 + 2 * LOG_N;

  logic               clk = 1'b0;
  logic               rst;
  logic               i_start;
  logic [LOG_N_W-1:0] i_stage;
  logic               o_busy, o_done, o_rd_en, o_wr_en;
  logic [LOG_N-1:0]   o_rd_addr_u, o_rd_addr_v, o_tw_addr, o_wr_addr_u, o_wr_addr_v;
  logic [1:0]         o_dbg_state;

  intt_stage_ctrl #(
    .LOG_N(LOG_N), .LOG_N_W(LOG_N_W), .MULRED_PIP_LEVEL(MULRED_PIP_LEVEL)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_stage(i_stage),
    .o_busy(o_busy), .o_done(o_done), .o_rd_en(o_rd_en),
    .o_rd_addr_u(o_rd_addr_u), .o_rd_addr_v(o_rd_addr_v), .o_tw_addr(o_tw_addr),
    .o_wr_en(o_wr_en), .o_wr_addr_u(o_wr_addr_u), .o_wr_addr_v(o_wr_addr_v),
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset / cycle counter
  int cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  int t_last;

  // model state
  bit               m_active = 1'b0;
  int               m_t = 0;
  int               m_s = 0;
  int               m_done_at = -1;
  logic [LOG_N-1:0] m_rd_u = '0, m_rd_v = '0, m_tw = '0, m_wr_u = '0, m_wr_v = '0;
  logic [QW-1:0]    exp_q[$];

  int rd_seen = 0, wr_seen = 0, done_seen = 0;
  int wr_cnt[N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  function automatic void pair_addr(input int s, input int k, output int u, output int v,
                                    output int tw);
    int len, g, j;
    len = 1 << s;
    g   = k / len;
    j   = k % len;
    u   = g * 2 * len + j;
    v   = u + len;
    tw  = N / (2 * len) + g;
  endfunction

  // scoreboard / compare process
  always @(negedge clk) begin
    logic          e_rd, e_wr, e_busy, e_done;
    int            u, v, tw;
    logic [QW-1:0] h;
    if (rst) begin
      m_active = 1'b0; m_done_at = -1;
      m_rd_u = '0; m_rd_v = '0; m_tw = '0; m_wr_u = '0; m_wr_v = '0;
      exp_q.delete();
      e_rd = 1'b0; e_wr = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    end else begin
      e_rd = m_active && cyc >= m_t + 1 && cyc <= m_t + HALF;
      if (e_rd) begin
        pair_addr(m_s, cyc - m_t - 1, u, v, tw);
        m_rd_u = LOG_N'(u); m_rd_v = LOG_N'(v); m_tw = LOG_N'(tw);
        exp_q.push_back({32'(cyc + 1 + BF_LAT), m_rd_u, m_rd_v});
      end
      e_wr = 1'b0;
      if (exp_q.size() > 0) begin
        h = exp_q[0];
        if (h[QW-1:2*LOG_N] == 32'(cyc)) begin
          void'(exp_q.pop_front());
          e_wr   = 1'b1;
          m_wr_u = h[2*LOG_N-1:LOG_N];
          m_wr_v = h[LOG_N-1:0];
        end
      end
      e_busy = m_active && cyc >= m_t + 1 && cyc <= m_t + HALF + BF_LAT + 1;
      e_done = (cyc == m_done_at);
    end
    check("rd_en", 32'(o_rd_en), 32'(e_rd));
    check("rd_addr_u", 32'(o_rd_addr_u), 32'(m_rd_u));
    check("rd_addr_v", 32'(o_rd_addr_v), 32'(m_rd_v));
    check("tw_addr", 32'(o_tw_addr), 32'(m_tw));
    check("wr_en", 32'(o_wr_en), 32'(e_wr));
    check("wr_addr_u", 32'(o_wr_addr_u), 32'(m_wr_u));
    check("wr_addr_v", 32'(o_wr_addr_v), 32'(m_wr_v));
    check("busy", 32'(o_busy), 32'(e_busy));
    check("done", 32'(o_done), 32'(e_done));
    if (o_rd_en === 1'b1) rd_seen++;
    if (o_done === 1'b1) done_seen++;
    if (o_wr_en === 1'b1) begin
      wr_seen++;
      wr_cnt[o_wr_addr_u]++;
      wr_cnt[o_wr_addr_v]++;
    end
    if (!rst && i_start && (!m_active || cyc >= m_done_at) && int'(i_stage) < LOG_N) begin
      m_active  = 1'b1;
      m_t       = cyc;
      m_s       = int'(i_stage);
      m_done_at = cyc + HALF + BF_LAT + 2;
    end
  end

  // driver tasks
  task automatic drive_start(input int s);
    @(posedge clk); #1;
    i_start = 1'b1;
    i_stage = LOG_N_W'(s);
    t_last  = cyc;
    @(posedge clk); #1;
    i_start = 1'b0;
    i_stage = LOG_N_W'(3);
  endtask

  task automatic at_cyc(input int target);
    @(negedge clk);
    while (cyc < target) @(negedge clk);
    check("at_cyc", 32'(cyc), 32'(target));
  endtask

  task automatic clear_counters();
    @(posedge clk); #1;
    rd_seen = 0; wr_seen = 0; done_seen = 0;
    for (int i = 0; i < N; i++) wr_cnt[i] = 0;
  endtask

  initial begin
    int t1, t2, t3, t4, t5, t6, tgt, once;
    rst = 1'b1; i_start = 1'b0; i_stage = '0;
    for (int i = 0; i < N; i++) wr_cnt[i] = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // stage 0, then stage 1 started on the done cycle
    drive_start(0); t1 = t_last;
    at_cyc(t1 + 6);
    check("s0_k5_rd_u", 32'(o_rd_addr_u), 32'd10);
    check("s0_k5_rd_v", 32'(o_rd_addr_v), 32'd11);
    check("s0_k5_tw", 32'(o_tw_addr), 32'd133);
    at_cyc(t1 + 13);
    check("s0_k5_wr_en", 32'(o_wr_en), 32'd1);
    check("s0_k5_wr_u", 32'(o_wr_addr_u), 32'd10);
    check("s0_k5_wr_v", 32'(o_wr_addr_v), 32'd11);
    at_cyc(t1 + 135);
    check("s0_last_wr_u", 32'(o_wr_addr_u), 32'd254);
    check("s0_last_wr_v", 32'(o_wr_addr_v), 32'd255);
    check("s0_last_busy", 32'(o_busy), 32'd1);
    drive_start(1); t2 = t_last;
    at_cyc(t2 + 2);
    check("s1_k1_rd_u", 32'(o_rd_addr_u), 32'd1);
    check("s1_k1_rd_v", 32'(o_rd_addr_v), 32'd3);
    check("s1_k1_tw", 32'(o_tw_addr), 32'd64);
    at_cyc(t2 + 136);
    check("s1_done", 32'(o_done), 32'd1);
    check("s1_done_busy", 32'(o_busy), 32'd0);

    // stage 3 spot pair
    at_cyc(t2 + 140);
    drive_start(3); t3 = t_last;
    at_cyc(t3 + 14);
    check("s3_k13_rd_u", 32'(o_rd_addr_u), 32'd21);
    check("s3_k13_rd_v", 32'(o_rd_addr_v), 32'd29);
    check("s3_k13_tw", 32'(o_tw_addr), 32'd17);
    at_cyc(t3 + 21);
    check("s3_k13_wr_u", 32'(o_wr_addr_u), 32'd21);
    check("s3_k13_wr_v", 32'(o_wr_addr_v), 32'd29);

    // stage 7 with an ignored start mid-run
    at_cyc(t3 + 140);
    clear_counters();
    drive_start(7); t4 = t_last;
    at_cyc(t4 + 20);
    check("s7_k19_rd_v", 32'(o_rd_addr_v), 32'd147);
    check("s7_k19_tw", 32'(o_tw_addr), 32'd1);
    at_cyc(t4 + 49);
    drive_start(2);
    at_cyc(t4 + 136);
    check("s7_done", 32'(o_done), 32'd1);
    at_cyc(t4 + 140);
    check("s7_done_count", 32'(done_seen), 32'd1);
    check("s7_read_count", 32'(rd_seen), 32'd128);
    check("s7_write_count", 32'(wr_seen), 32'd128);
    once = 0;
    for (int i = 0; i < N; i++) if (wr_cnt[i] == 1) once++;
    check("s7_written_once", 32'(once), 32'd256);

    // invalid stage while idle
    clear_counters();
    drive_start(8);
    tgt = cyc + 20;
    at_cyc(tgt);
    check("bad_stage_reads", 32'(rd_seen), 32'd0);
    check("bad_stage_done", 32'(done_seen), 32'd0);
    check("bad_stage_busy", 32'(o_busy), 32'd0);

    // reset mid-run
    drive_start(0); t5 = t_last;
    at_cyc(t5 + 59);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    check("rst_rd_en", 32'(o_rd_en), 32'd0);
    check("rst_rd_u", 32'(o_rd_addr_u), 32'd0);
    check("rst_tw", 32'(o_tw_addr), 32'd0);
    check("rst_wr_en", 32'(o_wr_en), 32'd0);
    check("rst_wr_u", 32'(o_wr_addr_u), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    clear_counters();
    tgt = cyc + 150;
    at_cyc(tgt);
    check("post_rst_writes", 32'(wr_seen), 32'd0);
    check("post_rst_reads", 32'(rd_seen), 32'd0);
    check("post_rst_done", 32'(done_seen), 32'd0);

    // fresh stage after reset
    clear_counters();
    drive_start(5); t6 = t_last;
    at_cyc(t6 + 41);
    check("s5_k40_rd_u", 32'(o_rd_addr_u), 32'd72);
    check("s5_k40_rd_v", 32'(o_rd_addr_v), 32'd104);
    check("s5_k40_tw", 32'(o_tw_addr), 32'd5);
    at_cyc(t6 + 140);
    check("s5_done_count", 32'(done_seen), 32'd1);
    check("s5_write_count", 32'(wr_seen), 32'd128);
    check("s5_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/intt_stage_ctrl.md
# intt_stage_ctrl

Address and sequencing controller for one Gentleman-Sande INTT layer. On a start pulse it walks all N/2 butterfly pairs of the selected stage, issuing one coefficient-pair read and one twiddle read per cycle to the coefficient/twiddle RAMs. Read data feeds the GS butterfly directly. The block also delays each pair's addresses by the full read-plus-butterfly latency and issues the matching write-back. It sits directly upstream of the butterfly, which consumes the RAM data this block addresses, and it owns the write-back of that butterfly's outputs.

## Interface
- LOG_N, 8, log2 of polynomial length N (N = 256 default)
- LOG_N_W, 3, width of stage select; must hold values 0..LOG_N-1
- MULRED_PIP_LEVEL, 5, butterfly multiplier pipeline depth; butterfly latency BF_LAT = MULRED_PIP_LEVEL + 1
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset; one clock, reset is asynchronous and active-high
- i_start  in  1  single-cycle request to run one stage
- i_stage  in  LOG_N_W  stage index s, sampled when start is accepted
- o_busy  out  1  high while a stage is in flight
- o_done  out  1  single-cycle pulse after the last write-back
- o_rd_en  out  1  coefficient and twiddle RAM read strobe; RAM read latency fixed at 1 cycle
- o_rd_addr_u  out  LOG_N  address of coefficient u
- o_rd_addr_v  out  LOG_N  address of coefficient v
- o_tw_addr  out  LOG_N  twiddle ROM address
- o_wr_en  out  1  write strobe for butterfly outputs o_u/o_v
- o_wr_addr_u  out  LOG_N  write address for o_u
- o_wr_addr_v  out  LOG_N  write address for o_v

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN when i_start=1 and i_stage < LOG_N; latch s, clear pair counter k.
  - i_start with i_stage >= LOG_N is ignored: no reads, no done.
  - RUN: o_rd_en=1 every cycle; k increments. After k = N/2-1 is issued -> DRAIN.
  - DRAIN: counts 1+BF_LAT cycles, until the last write has issued -> IDLE, and o_done pulses on the following cycle.
- i_start outside IDLE is ignored. No queuing. A change on i_stage during a run has no effect.
- Per pair k, with len = 2^s, g = k >> s, j = k & (len-1):
  - u = g*2*len + j
  - v = u + len
  - tw = (N >> (s+1)) + g
  - All values are unsigned LOG_N-bit and never overflow for valid s.
- Write-back delay line is 1+BF_LAT entries deep. Each entry holds {valid, u, v} shifted every cycle. Head entry drives o_wr_en, o_wr_addr_u and o_wr_addr_v.
- Each address is read exactly once and written later within a stage, so there is no RAW hazard within a stage. A next stage started on the o_done cycle reads only after all prior writes have completed.
- Reset (asynchronous, any time, including mid-run):
  - FSM goes to IDLE and the counter clears.
  - All delay-line valid bits clear, so no stray writes occur after reset.
  - All outputs are 0.

## Timing
- Start accepted at cycle T (IDLE, i_start=1).
- Reads: o_rd_en=1 on cycles T+1 .. T+N/2.
- Read-to-write latency per pair is 1+BF_LAT: a read issued at t produces a write at t+1+BF_LAT.
- Writes: o_wr_en=1 on cycles T+2+BF_LAT .. T+1+BF_LAT+N/2.
- o_busy=1 on cycles T+1 .. T+1+BF_LAT+N/2.
- o_done=1 on cycle T+2+BF_LAT+N/2 only, with o_busy=0 on that cycle. A new i_start is accepted on that same cycle.
- Defaults (N=256, BF_LAT=6):
  - reads on T+1..T+128
  - writes on T+8..T+135
  - done on T+136
- Outputs are registered. o_rd_addr_*, o_tw_addr and o_wr_addr_* hold their last values when their enable is low.

## Test plan
- Stage 0, start at T=0 -> at k=5 (cycle 6): rd u=10, v=11, tw=133. Matching write of u=10, v=11 at cycle 13. o_done at cycle 136.
- Stage 7 -> every k gives u=k, v=k+128, tw=1. 128 consecutive reads, then 128 writes. Every address 0..255 is written exactly once.
- Stage 3, k=13 -> rd u=21, v=29, tw=17. Scoreboard confirms each pair's write addresses equal its read addresses, 7 cycles later.
- i_start pulsed at T+50 during a run, and separately i_stage=8 while idle -> no extra reads, a single o_done at T+136, and nothing for the invalid stage.
- rst asserted at T+60 -> outputs are 0 immediately, and no o_wr_en occurs afterwards. A fresh start after reset runs a full, correct stage.
- Back-to-back: stage 0 then stage 1, with the second start on the o_done cycle (T+136) -> stage 1 reads on T+137..T+264. Stage 1 k=1: u=1, v=3, tw=64.
